// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle sequencer for the MIPS-subset core.
// Owns the program counter and instruction register. It steps the shared
// datapath through FETCH/DECODE/EXEC/MEM/WB, spending one state per cycle.
// Optional feature macro: CTRL_TRAP_EN. When it is defined, an unsupported
// encoding parks the sequencer in TRAP. When it is undefined, an unsupported
// encoding retires as a nop.
module multi_cycle_ctrl #(
    parameter int              PC_W     = 5,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic [31:0]     inst,
    input  logic            alu_zero,
    input  logic            mem_ready,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     ir,
    output logic [2:0]      state,
    output logic            reg_we,
    output logic            reg_dst,
    output logic            alu_src,
    output logic            ext_sign,
    output logic [2:0]      alu_op,
    output logic            mem_re,
    output logic            mem_we,
    output logic            mem_to_reg,
    output logic            trap,
    output logic [7:0]      instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t          state_r, state_s;
    logic [PC_W-1:0] pc_r, pc_s;
    logic [31:0]     ir_r, ir_s;
    logic            trap_r, trap_s;
    logic [7:0]      instret_r, instret_s;
    logic            retire_s;

    logic [5:0] opcode_s, funct_s;
    logic is_nop_s, is_j_s, is_rtype_s, is_ori_s, is_addiu_s;
    logic is_lw_s, is_sw_s, is_beq_s, is_exec_s;
    logic [2:0] rtype_op_s;

    // Instruction classification and R-type ALU operation from the latched word
    always_comb begin
        opcode_s   = ir_r[31:26];
        funct_s    = ir_r[5:0];
        is_nop_s   = (ir_r == 32'h0000_0000);
        is_j_s     = (opcode_s == 6'b000010);
        is_ori_s   = (opcode_s == 6'b001101);
        is_addiu_s = (opcode_s == 6'b001001);
        is_lw_s    = (opcode_s == 6'b100011);
        is_sw_s    = (opcode_s == 6'b101011);
        is_beq_s   = (opcode_s == 6'b000100);
        is_rtype_s = 1'b0;
        rtype_op_s = 3'd0;
        if (opcode_s == 6'b000000) begin
            case (funct_s)
                6'b100000: begin is_rtype_s = 1'b1; rtype_op_s = 3'd0; end
                6'b100010: begin is_rtype_s = 1'b1; rtype_op_s = 3'd1; end
                6'b100011: begin is_rtype_s = 1'b1; rtype_op_s = 3'd2; end
                6'b101010: begin is_rtype_s = 1'b1; rtype_op_s = 3'd3; end
                6'b101011: begin is_rtype_s = 1'b1; rtype_op_s = 3'd4; end
                default:   begin is_rtype_s = 1'b0; rtype_op_s = 3'd0; end
            endcase
        end else begin
            is_rtype_s = 1'b0;
            rtype_op_s = 3'd0;
        end
        is_exec_s = is_rtype_s | is_ori_s | is_addiu_s | is_lw_s | is_sw_s | is_beq_s;
    end

    // Next-state, architectural updates and per-state datapath controls
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        ir_s       = ir_r;
        trap_s     = trap_r;
        instret_s  = instret_r;
        retire_s   = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        ext_sign   = 1'b0;
        alu_op     = 3'd0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_to_reg = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (run) state_s = S_FETCH;
                else     state_s = S_IDLE;
            end
            S_FETCH: begin
                ir_s    = inst;
                pc_s    = pc_r + PC_W'(1);
                state_s = S_DECODE;
            end
            S_DECODE: begin
                if (is_nop_s) begin
                    retire_s = 1'b1;
                end else if (is_j_s) begin
                    pc_s     = ir_r[PC_W-1:0];
                    retire_s = 1'b1;
                end else if (is_exec_s) begin
                    state_s = S_EXEC;
                end else begin
`ifdef CTRL_TRAP_EN
                    state_s = S_TRAP;
                    trap_s  = 1'b1;
`else
                    retire_s = 1'b1;
`endif
                end
            end
            S_EXEC: begin
                alu_src  = is_ori_s | is_addiu_s | is_lw_s | is_sw_s;
                ext_sign = ~is_ori_s;
                if (is_rtype_s)     alu_op = rtype_op_s;
                else if (is_ori_s)  alu_op = 3'd5;
                else if (is_beq_s)  alu_op = 3'd1;
                else                alu_op = 3'd0;
                if (is_rtype_s | is_ori_s | is_addiu_s) begin
                    state_s = S_WB;
                end else if (is_lw_s | is_sw_s) begin
                    state_s = S_MEM;
                end else begin
                    // beq: target is relative to the already-incremented pc
                    if (alu_zero) pc_s = pc_r + ir_r[PC_W-1:0];
                    else          pc_s = pc_r;
                    retire_s = 1'b1;
                end
            end
            S_MEM: begin
                mem_re = is_lw_s;
                mem_we = is_sw_s;
                if (mem_ready) begin
                    if (is_lw_s) state_s = S_WB;
                    else         retire_s = 1'b1;
                end else begin
                    state_s = S_MEM;
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                reg_dst    = is_rtype_s;
                mem_to_reg = is_lw_s;
                retire_s   = 1'b1;
            end
            S_TRAP: begin
                state_s = S_TRAP;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
        if (retire_s) begin
            state_s = run ? S_FETCH : S_IDLE;
            if (instret_r != 8'hFF) instret_s = instret_r + 8'd1;
            else                    instret_s = instret_r;
        end else begin
            instret_s = instret_r;
        end
    end

    // Architectural state registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            pc_r      <= RESET_PC;
            ir_r      <= 32'h0000_0000;
            trap_r    <= 1'b0;
            instret_r <= 8'h00;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            ir_r      <= ir_s;
            trap_r    <= trap_s;
            instret_r <= instret_s;
        end
    end

    assign pc      = pc_r;
    assign ir      = ir_r;
    assign state   = state_r;
    assign trap    = trap_r;
    assign instret = instret_r;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed testbench for multi_cycle_ctrl with a small ROM model.
module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [31:0] inst;
    logic        alu_zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic [4:0]  pc;
    logic [31:0] ir;
    logic [2:0]  state;
    logic        reg_we, reg_dst, alu_src, ext_sign;
    logic [2:0]  alu_op;
    logic        mem_re, mem_we, mem_to_reg, trap;
    logic [7:0]  instret;

    logic [31:0] rom [0:31];
    int vectors = 0;
    int miscompares = 0;

    multi_cycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .run(run), .inst(inst),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .pc(pc), .ir(ir), .state(state), .reg_we(reg_we),
        .reg_dst(reg_dst), .alu_src(alu_src), .ext_sign(ext_sign),
        .alu_op(alu_op), .mem_re(mem_re), .mem_we(mem_we),
        .mem_to_reg(mem_to_reg), .trap(trap), .instret(instret)
    );

    always #5 clk = ~clk;

    always_comb inst = rom[pc];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = 32'h0000_0000;
    endtask

    // Hold reset for two cycles, then release it away from the clock edge
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        clear_rom();
        rom[1] = 32'h0085_0820;  // add r1,r4,r5
        run = 1'b0;
        #2;
        // Reset state, taken while rst_n is low
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_pc", {27'd0, pc}, 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk("rst_instret", {24'd0, instret}, 32'd0);
        chk("rst_strobes", {24'd0, reg_we, mem_re, mem_we, mem_to_reg, alu_src, reg_dst, ext_sign, 1'b0}, 32'd0);
        do_reset();

        // nop then add
        run = 1'b1;
        tick();  chk("t1_fetch", {29'd0, state}, 32'd1);
        tick();  chk("t1_pc_after_nop_fetch", {27'd0, pc}, 32'd1);
        chk("t1_decode", {29'd0, state}, 32'd2);
        tick();  chk("t1_nop_retire", {24'd0, instret}, 32'd1);
        tick();  chk("t1_add_ir", ir, 32'h0085_0820);
        tick();  chk("t1_exec", {29'd0, state}, 32'd3);
        chk("t1_exec_alu_src", {31'd0, alu_src}, 32'd0);
        chk("t1_exec_reg_we", {31'd0, reg_we}, 32'd0);
        tick();  chk("t1_wb", {29'd0, state}, 32'd5);
        chk("t1_wb_ctl", {29'd0, reg_we, reg_dst, mem_to_reg}, 32'b110);
        chk("t1_wb_alu_op", {29'd0, alu_op}, 32'd0);
        tick();  chk("t1_instret2", {24'd0, instret}, 32'd2);
        chk("t1_refetch", {29'd0, state}, 32'd1);
        run = 1'b0;
        tick();
        tick();  chk("t1_idle", {29'd0, state}, 32'd0);
        chk("t1_instret3", {24'd0, instret}, 32'd3);

        // lw with three wait cycles
        clear_rom();
        rom[0] = 32'h8CE8_0002;
        mem_ready = 1'b0;
        do_reset();
        run = 1'b1;
        tick();
        tick();
        tick();  chk("lw_exec_ctl", {28'd0, alu_src, ext_sign, mem_re, reg_we}, 32'b1100);
        chk("lw_exec_alu_op", {29'd0, alu_op}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();  chk("lw_mem_wait", {29'd0, state, 1'b0, mem_re, mem_we} >> 0, {29'd0, 3'd4, 1'b0, 1'b1, 1'b0});
        end
        mem_ready = 1'b1;
        chk("lw_mem_last", {30'd0, mem_re, mem_we}, 32'b10);
        run = 1'b0;
        tick();  chk("lw_wb", {29'd0, state}, 32'd5);
        chk("lw_wb_ctl", {28'd0, reg_we, reg_dst, mem_to_reg, mem_re}, 32'b1010);
        tick();  chk("lw_idle", {29'd0, state}, 32'd0);
        chk("lw_instret", {24'd0, instret}, 32'd1);
        mem_ready = 1'b0;

        // j / beq taken / j / beq not taken / j to 0x1F / pc wrap
        clear_rom();
        rom[0]  = 32'h0800_000A;
        rom[10] = 32'h1063_0001;
        rom[12] = 32'h0800_0008;
        rom[8]  = 32'h1063_0001;
        rom[9]  = 32'h0800_001F;
        do_reset();
        run = 1'b1;
        alu_zero = 1'b0;
        tick();
        tick();
        tick();  chk("j_pc_0a", {27'd0, pc}, 32'h0A);
        tick();  chk("beq_fetch_pc", {27'd0, pc}, 32'h0B);
        tick();  chk("beq_exec_ctl", {29'd0, alu_src, ext_sign, 1'b0}, 32'b010);
        chk("beq_exec_alu_op", {29'd0, alu_op}, 32'd1);
        alu_zero = 1'b1;
        tick();  chk("beq_taken_pc", {27'd0, pc}, 32'h0C);
        chk("beq_taken_instret", {24'd0, instret}, 32'd2);
        alu_zero = 1'b0;
        tick();
        tick();  chk("j_pc_08", {27'd0, pc}, 32'h08);
        tick();
        tick();  chk("beq_nt_exec_pc", {27'd0, pc}, 32'h09);
        tick();  chk("beq_nt_pc", {27'd0, pc}, 32'h09);
        chk("beq_nt_instret", {24'd0, instret}, 32'd4);
        tick();
        tick();  chk("j_pc_1f", {27'd0, pc}, 32'h1F);
        tick();  chk("pc_wrap", {27'd0, pc}, 32'h00);
        run = 1'b0;
        tick();  chk("wrap_idle", {29'd0, state}, 32'd0);
        chk("wrap_instret", {24'd0, instret}, 32'd6);

        // Unsupported opcode 0x3F
        clear_rom();
        rom[0] = 32'hFC00_0000;
        do_reset();
        run = 1'b1;
        tick();
        tick();
        tick();
`ifdef CTRL_TRAP_EN
        chk("trap_state", {29'd0, state}, 32'd6);
        chk("trap_flag", {31'd0, trap}, 32'd1);
        tick();  chk("trap_hold", {29'd0, state}, 32'd6);
        chk("trap_pc_frozen", {27'd0, pc}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("trap_rst_state", {29'd0, state}, 32'd0);
        chk("trap_rst_flag", {31'd0, trap}, 32'd0);
`else
        chk("illegal_as_nop", {29'd0, state}, 32'd1);
        chk("illegal_instret", {24'd0, instret}, 32'd1);
        chk("illegal_no_trap", {31'd0, trap}, 32'd0);
`endif

        // Reset during a sw memory wait
        clear_rom();
        rom[0] = 32'hACE8_0002;
        mem_ready = 1'b0;
        do_reset();
        run = 1'b1;
        tick();
        tick();
        tick();
        tick();  chk("sw_mem_we", {29'd0, state, mem_we} >> 0, {28'd0, 3'd4, 1'b1});
        tick();  chk("sw_wait_hold", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("sw_rst_state", {29'd0, state}, 32'd0);
        chk("sw_rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("sw_rst_pc", {27'd0, pc}, 32'd0);

        // run dropped during EXEC of an add
        clear_rom();
        rom[0] = 32'h0085_0820;
        do_reset();
        run = 1'b1;
        tick();
        tick();
        tick();  chk("rd_exec", {29'd0, state}, 32'd3);
        run = 1'b0;
        tick();  chk("rd_wb", {29'd0, state}, 32'd5);
        tick();  chk("rd_idle", {29'd0, state}, 32'd0);
        chk("rd_instret", {24'd0, instret}, 32'd1);
        tick();  chk("rd_idle_hold", {29'd0, state}, 32'd0);

        // instret saturation on a stream of nops
        clear_rom();
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 1 + 2 * 254; i++) tick();
        chk("sat_fe", {24'd0, instret}, 32'hFE);
        tick();
        tick();  chk("sat_ff", {24'd0, instret}, 32'hFF);
        for (int i = 0; i < 4; i++) tick();
        chk("sat_hold", {24'd0, instret}, 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Multi-cycle sequencer for the MIPS-subset core. It owns the 5-bit program counter that addresses the instruction ROM and latches the returned word into an instruction register. It decodes the word and steps the shared datapath (register file, ALU, data memory) through fetch/decode/execute/memory/writeback, one state per cycle, with a wait handshake on data memory.

## Interface
- PC_W, 5, program counter width (word index into instruction ROM)
- RESET_PC, 0, PC value loaded at reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  start/continue execution; sampled only at instruction boundaries
- inst  in  32  instruction word from ROM at address pc
- alu_zero  in  1  ALU result == 0 (valid in EXEC)
- mem_ready  in  1  data memory completes access this cycle
- pc  out  PC_W  registered program counter to ROM
- ir  out  32  registered instruction
- state  out  3  current state encoding
- reg_we  out  1  register-file write strobe
- reg_dst  out  1  1 = write rd (R-type), 0 = write rt
- alu_src  out  1  1 = immediate operand B, 0 = rt
- ext_sign  out  1  1 = sign-extend imm16, 0 = zero-extend
- alu_op  out  3  0 add, 1 sub, 2 subu, 3 slt, 4 sltu, 5 or
- mem_re / mem_we  out  1 each  data memory read / write request
- mem_to_reg  out  1  writeback source is memory
- trap  out  1  sticky illegal-instruction flag
- instret  out  8  retired-instruction count, saturating

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- IDLE: run=1 -> FETCH; otherwise hold.
- FETCH: ir <= inst; pc <= pc+1 (mod 2^PC_W) -> DECODE.
- DECODE: ir==0 (nop) retires. j (op 000010) pc <= ir[PC_W-1:0], retires. Supported R-type funct 100000/100010/100011/101010/101011, ori 001101, addiu 001001, lw 100011, sw 101011, beq 000100 -> EXEC. Anything else -> TRAP.
- EXEC: R-type/ori/addiu -> WB. lw/sw -> MEM. beq: if alu_zero, pc <= pc + imm16[PC_W-1:0] (relative to incremented pc, wraps); retires.
- MEM: mem_re (lw) or mem_we (sw) held until mem_ready=1. lw -> WB; sw retires.
- WB: reg_we=1 for one cycle; mem_to_reg=1 for lw; retires.
- Retire: instret += 1 unless already 0xFF. Next state FETCH if run=1, else IDLE.
- Controls: combinational from state and ir; all zero outside the state that uses them. alu_src=1 and reg_dst=0 for ori/addiu/lw/sw. ext_sign=0 only for ori. alu_op: add for addiu/lw/sw, sub for beq.
- TRAP: trap=1, all strobes 0, pc/ir frozen; exits only on reset.

## Timing
- Reset (async, any state, including mid-MEM wait): state=IDLE, pc=RESET_PC, ir=0, trap=0, instret=0, all strobes 0.
- Cycles per instruction (mem_ready immediate): nop 2, j 2, beq 3, R/ori/addiu 4, sw 4, lw 5; each cycle mem_ready=0 in MEM adds one.
- pc changes only on FETCH exit, j in DECODE, or taken beq in EXEC.
- run deassert mid-instruction: instruction completes, then IDLE.
- mem_ready is ignored outside MEM.
- Simultaneous retire and instret==0xFF: count holds.

## Configuration
- CTRL_TRAP_EN defined: unsupported encodings enter TRAP as above.
- Undefined: unsupported encodings retire as nop in DECODE; trap tied 0; TRAP state unreachable.

## Test plan
- Reset, run=1, ROM word 0 = 0x00000000, word 1 = add r1,r4,r5 -> pc 0->1 after 2 cycles; for word 1, reg_we=1, reg_dst=1, alu_op=0 in WB on cycle 4 of that instruction; instret=2.
- lw 0x8CE80002 with mem_ready low 3 cycles -> mem_re high 4 cycles, then WB with mem_to_reg=1; total 8 cycles.
- beq 0x10630001 at pc=0x0A, alu_zero=1 -> pc=0x0C after EXEC. With alu_zero=0 -> pc=0x0B.
- j 0x08000008 at pc=0x0C -> pc=0x08 after DECODE. pc=0x1F, FETCH -> pc wraps to 0x00.
- Opcode 0x3F with CTRL_TRAP_EN -> state=6, trap=1, pc frozen; rst_n low -> IDLE, trap=0. Without the macro -> retires as nop.
- Drop rst_n during MEM wait -> immediate IDLE, mem_we=0. run=0 during EXEC -> instruction retires, then IDLE.
